// File: rtl/delta_adc_pkg.sv
// Shared constants and arithmetic helpers for the delta-modulation ADC back-end.
package delta_adc_pkg;

  localparam logic MODE_LINEAR   = 1'b0;
  localparam logic MODE_ADAPTIVE = 1'b1;

  // Saturating add/sub of two unsigned width-bit values, clamped to [0, 2^width-1].
  // Operands travel in 32-bit containers; the arithmetic is done two bits wider so
  // both overflow and underflow stay representable before clamping.
  function automatic logic [31:0] sat_addsub(input logic [31:0] a,
                                             input logic [31:0] b,
                                             input logic        add,
                                             input int unsigned width);
    logic signed [33:0] sum;
    logic signed [33:0] max_v;
    max_v = (34'sd1 <<< width) - 34'sd1;
    if (add) begin
      sum = $signed({2'b00, a}) + $signed({2'b00, b});
    end else begin
      sum = $signed({2'b00, a}) - $signed({2'b00, b});
    end
    if (sum < 34'sd0) begin
      return 32'd0;
    end else if (sum > max_v) begin
      return max_v[31:0];
    end else begin
      return sum[31:0];
    end
  endfunction

endpackage

// File: rtl/delta_adc_step_ctrl.sv
// CVSD-style step adaptation: grows the step exponent on runs of identical
// comparator bits and shrinks it on alternation.
module delta_adc_step_ctrl import delta_adc_pkg::*; #(
  parameter int unsigned RUN_LEN   = 3,
  parameter int unsigned MAX_SHIFT = 4,
  parameter int unsigned SHIFT_W   = $clog2(MAX_SHIFT + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en_i,
  input  logic               mode_i,
  input  logic               cmp_s_i,
  output logic [SHIFT_W-1:0] shift_o
);

  localparam int unsigned HistW = RUN_LEN - 1;
  localparam logic [SHIFT_W-1:0] MaxShiftV = SHIFT_W'(MAX_SHIFT);

  logic [HistW-1:0]   hist_q, hist_d;
  logic [SHIFT_W-1:0] shift_q, shift_d;
  logic               run;

  // Next history and shift exponent; linear mode pins the exponent to zero every clock.
  always_comb begin
    hist_d  = hist_q;
    shift_d = shift_q;
    run     = (hist_q == {HistW{cmp_s_i}});
    if (en_i) begin
      // Newest bit enters at index 0, oldest drops off the top.
      hist_d = HistW'({hist_q, cmp_s_i});
      if (mode_i == MODE_ADAPTIVE) begin
        if (run) begin
          if (shift_q < MaxShiftV) shift_d = shift_q + 1'b1;
        end else if (cmp_s_i != hist_q[0]) begin
          if (shift_q != '0) shift_d = shift_q - 1'b1;
        end
      end
    end
    if (mode_i == MODE_LINEAR) shift_d = '0;
  end

  // History and exponent state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q  <= '0;
      shift_q <= '0;
    end else begin
      hist_q  <= hist_d;
      shift_q <= shift_d;
    end
  end

  assign shift_o = shift_q;

endmodule

// File: rtl/delta_adc_tracker.sv
// Delta-modulation ADC back-end: comparator synchroniser, saturating tracking
// accumulator driving the feedback DAC, decimator and valid/ready sample port.
module delta_adc_tracker import delta_adc_pkg::*; #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DECIM     = 16,
  parameter int unsigned RUN_LEN   = 3,
  parameter int unsigned MAX_SHIFT = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en_i,
  input  logic               mode_i,
  input  logic               cmp_i,
  output logic [WIDTH-1:0]   dac_o,
  output logic [MAX_SHIFT:0] step_o,
  output logic [WIDTH-1:0]   sample_o,
  output logic               sample_valid_o,
  input  logic               sample_ready_i,
  input  logic               overrun_clr_i,
  output logic               overrun_o
);

  localparam int unsigned SHIFT_W = $clog2(MAX_SHIFT + 1);
  localparam int unsigned CNT_W   = $clog2(DECIM);
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DECIM - 1);
  localparam logic [WIDTH-1:0] AccMid  = WIDTH'(1) << (WIDTH - 1);

  logic               cmp_meta_q, cmp_s_q;
  logic [SHIFT_W-1:0] shift;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   sample_q;
  logic               valid_q, overrun_q;
  logic               capture;

  delta_adc_step_ctrl #(
    .RUN_LEN  (RUN_LEN),
    .MAX_SHIFT(MAX_SHIFT),
    .SHIFT_W  (SHIFT_W)
  ) u_step_ctrl (
    .clk    (clk),
    .rst    (rst),
    .en_i   (en_i),
    .mode_i (mode_i),
    .cmp_s_i(cmp_s_q),
    .shift_o(shift)
  );

  assign step_o  = (MAX_SHIFT + 1)'(1) << shift;
  assign acc_d   = WIDTH'(sat_addsub(32'(acc_q), 32'(step_o), cmp_s_q, WIDTH));
  assign capture = en_i && (cnt_q == CntLast);

  // Two-flop synchroniser for the asynchronous comparator; free-running.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmp_meta_q <= 1'b0;
      cmp_s_q    <= 1'b0;
    end else begin
      cmp_meta_q <= cmp_i;
      cmp_s_q    <= cmp_meta_q;
    end
  end

  // Tracking accumulator and decimation counter advance only on enabled cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= AccMid;
      cnt_q <= '0;
    end else if (en_i) begin
      acc_q <= acc_d;
      cnt_q <= (cnt_q == CntLast) ? '0 : cnt_q + 1'b1;
    end
  end

  // Sample register, valid/ready handshake and sticky overrun (set beats clear).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_q  <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      if (capture && (!valid_q || sample_ready_i)) begin
        sample_q <= acc_q;
        valid_q  <= 1'b1;
      end else if (valid_q && sample_ready_i) begin
        valid_q <= 1'b0;
      end
      if (capture && valid_q && !sample_ready_i) begin
        overrun_q <= 1'b1;
      end else if (overrun_clr_i) begin
        overrun_q <= 1'b0;
      end
    end
  end

  assign dac_o          = acc_q;
  assign sample_o       = sample_q;
  assign sample_valid_o = valid_q;
  assign overrun_o      = overrun_q;

endmodule
